dm_responder: RTL and testbench

Data-memory responder at the far end of the core's DM port. It accepts the single-cycle `DM_enable`/`DM_read`/`DM_write` strobes, address and write data, and services them from an internal word array. Read data returns after a fixed, parameterised latency, and a busy flag covers the latency window. It also flags illegal accesses and keeps saturating access counters for debug. It sits beside the core in the SoC top, wired directly to `DM_address`, `DM_in` and `DM_out`.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_responder_sat_counter.sv | 24 ++
 rtl/dm_responder.sv | 135 +++++++++++++
 tb/tb_dm_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dm_pkg;

   // Default widths used by the responder when not overridden
   localparam int unsigned DM_ADDR_W = 12;
   localparam int unsigned DM_DATA_W = 32;
   localparam int unsigned DM_CNT_W  = 16;

   // Supported read-latency range
   localparam int unsigned DM_RD_LAT_MIN = 1;
   localparam int unsigned DM_RD_LAT_MAX = 4;

   // Width of the latency down-counter, sized for the largest latency
   localparam int unsigned DM_LAT_W = $clog2(DM_RD_LAT_MAX + 1);

   // Responder FSM: IDLE accepts requests, WAIT covers the read latency window
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } dm_state_e;

endpackage : dm_pkg

// File: rtl/dm_responder_sat_counter.sv
// Width-parameterised event counter that sticks at its maximum value.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // Count accepted events; hold at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule : sat_counter

// File: rtl/dm_responder.sv
// Data-memory responder: word array with fixed read latency, busy/error flags
// and saturating access counters.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W       = DM_ADDR_W,
   parameter int unsigned DATA_W       = DM_DATA_W,
   parameter int unsigned DEPTH        = 4096,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned CNT_W        = DM_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DM_enable,
   input  logic              DM_read,
   input  logic              DM_write,
   input  logic [ADDR_W-1:0] DM_address,
   input  logic [DATA_W-1:0] DM_in,
   output logic [DATA_W-1:0] DM_out,
   output logic              DM_busy,
   output logic              DM_error,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [DM_LAT_W-1:0] LAT_LOAD = DM_LAT_W'(READ_LATENCY - 1);

   dm_state_e         state_q, state_d;
   logic [DM_LAT_W-1:0] lat_q, lat_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              in_range_c;
   logic              legal_c;
   logic              rd_acc_c;
   logic              wr_acc_c;
   logic [IDX_W-1:0]  idx_c;

   // Request qualification: only IDLE, one-hot read/write, in-range address
   assign idx_c      = DM_address[IDX_W-1:0];
   assign in_range_c = ({1'b0, DM_address} < DEPTH_L);
   assign legal_c    = DM_enable && (state_q == ST_IDLE) &&
                       (DM_read ^ DM_write) && in_range_c;
   assign rd_acc_c   = legal_c && DM_read;
   assign wr_acc_c   = legal_c && DM_write;

   // Next-state and output logic for the read-latency FSM
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      out_d   = out_q;
      busy_d  = busy_q;
      err_d   = DM_enable && !legal_c;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (rd_acc_c) begin
               addr_d = idx_c;
               if (READ_LATENCY <= 1) begin
                  out_d = mem_q[idx_c];
               end else begin
                  state_d = ST_WAIT;
                  lat_d   = LAT_LOAD;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (lat_q == DM_LAT_W'(1)) begin
               out_d   = mem_q[addr_q];
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               lat_d = lat_q - DM_LAT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and output registers; reset aborts any in-flight read
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
         addr_q  <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Word array, deliberately not reset; writes commit at the request edge
   always_ff @(posedge clk) begin
      if (wr_acc_c) begin
         mem_q[idx_c] <= DM_in;
      end
   end

   sat_counter #(.W(CNT_W)) u_rd_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (rd_acc_c),
      .count_o (rd_count)
   );

   sat_counter #(.W(CNT_W)) u_wr_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (wr_acc_c),
      .count_o (wr_count)
   );

   assign DM_out   = out_q;
   assign DM_busy  = busy_q;
   assign DM_error = err_q;

endmodule : dm_responder

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (latency 1 / 3 / 4) share a
// request bus, steered by sel; read results are checked against a scoreboard.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, rd, wr;
   logic [11:0] addr;
   logic [31:0] din;
   logic [1:0]  sel;

   logic        en0, en1, en2;
   logic [31:0] out0, out1, out2;
   logic        busy0, busy1, busy2;
   logic        err0, err1, err2;
   logic [3:0]  rdc0, wrc0;
   logic [15:0] rdc1, wrc1, rdc2, wrc2;

   logic [31:0] o_out;
   logic        o_busy, o_err;
   logic [15:0] o_rd, o_wr;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_wr;
   int          n;

   always #5 clk = ~clk;

   assign en0 = en && (sel == 2'd0);
   assign en1 = en && (sel == 2'd1);
   assign en2 = en && (sel == 2'd2);

   // Instance A: latency 1, 1024 words, 4-bit counters
   dm_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .READ_LATENCY(1), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst), .DM_enable(en0), .DM_read(rd), .DM_write(wr),
      .DM_address(addr), .DM_in(din), .DM_out(out0), .DM_busy(busy0),
      .DM_error(err0), .rd_count(rdc0), .wr_count(wrc0));

   // Instance B: latency 3
   dm_responder #(.READ_LATENCY(3)) u_b (
      .clk(clk), .rst(rst), .DM_enable(en1), .DM_read(rd), .DM_write(wr),
      .DM_address(addr), .DM_in(din), .DM_out(out1), .DM_busy(busy1),
      .DM_error(err1), .rd_count(rdc1), .wr_count(wrc1));

   // Instance C: latency 4
   dm_responder #(.READ_LATENCY(4)) u_c (
      .clk(clk), .rst(rst), .DM_enable(en2), .DM_read(rd), .DM_write(wr),
      .DM_address(addr), .DM_in(din), .DM_out(out2), .DM_busy(busy2),
      .DM_error(err2), .rd_count(rdc2), .wr_count(wrc2));

   // Observe the currently selected instance
   always_comb begin
      o_out  = out0;
      o_busy = busy0;
      o_err  = err0;
      o_rd   = 16'(rdc0);
      o_wr   = 16'(wrc0);
      case (sel)
         2'd1: begin
            o_out = out1; o_busy = busy1; o_err = err1; o_rd = rdc1; o_wr = wrc1;
         end
         2'd2: begin
            o_out = out2; o_busy = busy2; o_err = err2; o_rd = rdc2; o_wr = wrc2;
         end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      en = 1'b0; rd = 1'b0; wr = 1'b0;
   endtask

   task automatic drive(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
      en = 1'b1; rd = r; wr = w; addr = a; din = d;
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, o_out, e);
      end
   endtask

   initial begin
      rst = 1'b0; sel = 2'd0; addr = '0; din = '0;
      idle();
      tick(); tick();
      rst = 1'b1;

      // Reset state of every instance
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         chk($sformatf("rst_out%0d", k),  o_out, 32'h0);
         chk($sformatf("rst_busy%0d", k), 32'(o_busy), 32'h0);
         chk($sformatf("rst_err%0d", k),  32'(o_err), 32'h0);
         chk($sformatf("rst_rd%0d", k),   32'(o_rd), 32'h0);
         chk($sformatf("rst_wr%0d", k),   32'(o_wr), 32'h0);
      end

      // Latency 1: write then read same address on consecutive cycles
      sel = 2'd0;
      drive(1'b0, 1'b1, 12'h005, 32'hDEADBEEF);
      tick();
      chk("a_wr_busy", 32'(o_busy), 32'h0);
      drive(1'b1, 1'b0, 12'h005, 32'h0);
      exp_q.push_back(32'hDEADBEEF);
      tick();
      idle();
      pop_chk("a_rd_data");
      chk("a_rd_busy", 32'(o_busy), 32'h0);
      chk("a_wr_cnt", 32'(o_wr), 32'h1);
      chk("a_rd_cnt", 32'(o_rd), 32'h1);

      // Illegal encodings: both set, then both clear
      drive(1'b1, 1'b1, 12'h010, 32'h11111111);
      tick();
      idle();
      chk("a_both_err", 32'(o_err), 32'h1);
      tick();
      chk("a_both_clr", 32'(o_err), 32'h0);
      drive(1'b0, 1'b0, 12'h010, 32'h0);
      tick();
      idle();
      chk("a_none_err", 32'(o_err), 32'h1);
      tick();
      chk("a_none_clr", 32'(o_err), 32'h0);
      chk("a_ill_out", o_out, 32'hDEADBEEF);
      chk("a_ill_wr", 32'(o_wr), 32'h1);
      chk("a_ill_rd", 32'(o_rd), 32'h1);

      // Out of range with 1024 words
      drive(1'b0, 1'b1, 12'h400, 32'hAAAA5555);
      tick();
      idle();
      chk("a_oor_wr_err", 32'(o_err), 32'h1);
      tick();
      drive(1'b1, 1'b0, 12'h400, 32'h0);
      tick();
      idle();
      chk("a_oor_rd_err", 32'(o_err), 32'h1);
      tick();
      chk("a_oor_out", o_out, 32'hDEADBEEF);
      chk("a_oor_wr", 32'(o_wr), 32'h1);
      chk("a_oor_rd", 32'(o_rd), 32'h1);

      // Saturation of the 4-bit write counter over 20 writes
      exp_wr = 16'd1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 12'(32'h20 + i), 32'h100 + 32'(i));
         tick();
         exp_wr = (exp_wr == 16'd15) ? 16'd15 : exp_wr + 16'd1;
         chk($sformatf("a_sat_%0d", i), 32'(o_wr), 32'(exp_wr));
      end
      drive(1'b1, 1'b0, 12'h023, 32'h0);
      exp_q.push_back(32'h103);
      tick();
      idle();
      pop_chk("a_sat_rdback");

      // Latency 3 with a second request during WAIT
      sel = 2'd1;
      drive(1'b0, 1'b1, 12'h0FF, 32'h12345678);
      tick();
      drive(1'b1, 1'b0, 12'h0FF, 32'h0);
      exp_q.push_back(32'h12345678);
      tick();
      chk("b_busy1", 32'(o_busy), 32'h1);
      chk("b_out_early1", o_out, 32'h0);
      tick();
      idle();
      chk("b_busy2", 32'(o_busy), 32'h1);
      chk("b_wait_err", 32'(o_err), 32'h1);
      chk("b_out_early2", o_out, 32'h0);
      tick();
      chk("b_busy_done", 32'(o_busy), 32'h0);
      chk("b_err_clr", 32'(o_err), 32'h0);
      pop_chk("b_rd_data");
      chk("b_rd_cnt", 32'(o_rd), 32'h1);

      // Latency 4: reset aborts an in-flight read
      sel = 2'd2;
      drive(1'b0, 1'b1, 12'h001, 32'hCAFEF00D);
      tick();
      drive(1'b1, 1'b0, 12'h001, 32'h0);
      tick();
      idle();
      chk("c_busy_pre", 32'(o_busy), 32'h1);
      rst = 1'b0;
      tick();
      chk("c_rst_busy", 32'(o_busy), 32'h0);
      chk("c_rst_out", o_out, 32'h0);
      rst = 1'b1;
      tick();
      chk("c_rst_out_hold", o_out, 32'h0);
      drive(1'b1, 1'b0, 12'h001, 32'h0);
      exp_q.push_back(32'hCAFEF00D);
      tick();
      idle();
      n = 0;
      while (o_busy && n < 10) begin
         tick();
         n++;
      end
      chk("c_busy_len", 32'(n), 32'd3);
      pop_chk("c_rd_data");
      chk("c_rd_cnt", 32'(o_rd), 32'h1);
      chk("sb_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dm_responder
